// File: rtl/imem_loader_if.sv
// Handshake and memory-write bundle between the boot-byte source, the loader
// and the writable instruction memory.
interface imem_loader_if #(
    parameter int ADDR_W = 6
);
    logic              start;
    logic [ADDR_W:0]   word_count;
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_hold;
    logic              done;
    logic [31:0]       checksum;

    modport master (
        output start, word_count, byte_in, byte_valid,
        input  byte_ready, imem_we, imem_addr, imem_wdata, cpu_hold, done, checksum
    );

    modport slave (
        input  start, word_count, byte_in, byte_valid,
        output byte_ready, imem_we, imem_addr, imem_wdata, cpu_hold, done, checksum
    );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: packs a little-endian byte stream into 32-bit words, writes them
// to consecutive instruction-memory addresses and holds the core until done.
module imem_loader #(
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64
) (
    input logic          clk,
    input logic          rst,
    imem_loader_if.slave bus
);
    // state   | meaning
    // IDLE    | waiting for start, core held
    // COLLECT | accepting bytes of the current word
    // WRITE   | one-cycle memory write of the assembled word
    // DONE    | load complete, core released
    typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    state_t            state;
    logic [1:0]        byte_idx;
    logic [ADDR_W-1:0] word_idx;
    logic [ADDR_W:0]   count;
    logic [23:0]       asm_word;
    logic [ADDR_W:0]   start_count;
    logic              last_word;

    assign start_count = (bus.word_count > DEPTH_C) ? DEPTH_C : bus.word_count;
    assign last_word   = ({1'b0, word_idx} == (count - 1'b1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            byte_idx       <= '0;
            word_idx       <= '0;
            count          <= '0;
            asm_word       <= '0;
            bus.byte_ready <= 1'b0;
            bus.imem_we    <= 1'b0;
            bus.imem_addr  <= '0;
            bus.imem_wdata <= '0;
            bus.cpu_hold   <= 1'b1;
            bus.done       <= 1'b0;
            bus.checksum   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        count        <= start_count;
                        bus.checksum <= '0;
                        word_idx     <= '0;
                        byte_idx     <= '0;
                        if (start_count == '0) begin
                            state          <= DONE;
                            bus.done       <= 1'b1;
                            bus.cpu_hold   <= 1'b0;
                            bus.byte_ready <= 1'b0;
                        end else begin
                            state          <= COLLECT;
                            bus.done       <= 1'b0;
                            bus.cpu_hold   <= 1'b1;
                            bus.byte_ready <= 1'b1;
                        end
                    end
                end
                COLLECT: begin
                    if (bus.byte_valid && bus.byte_ready) begin
                        byte_idx <= byte_idx + 2'd1;
                        case (byte_idx)
                            2'd0: asm_word[7:0]   <= bus.byte_in;
                            2'd1: asm_word[15:8]  <= bus.byte_in;
                            2'd2: asm_word[23:16] <= bus.byte_in;
                            default: begin
                                // Fourth byte goes straight into the write data.
                                bus.imem_we    <= 1'b1;
                                bus.imem_addr  <= word_idx;
                                bus.imem_wdata <= {bus.byte_in, asm_word};
                                bus.byte_ready <= 1'b0;
                                state          <= WRITE;
                            end
                        endcase
                    end
                end
                WRITE: begin
                    bus.imem_we  <= 1'b0;
                    bus.checksum <= bus.checksum + bus.imem_wdata;
                    if (last_word) begin
                        state        <= DONE;
                        bus.done     <= 1'b1;
                        bus.cpu_hold <= 1'b0;
                    end else begin
                        word_idx       <= word_idx + 1'b1;
                        state          <= COLLECT;
                        bus.byte_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader; writes and handshakes are logged
// by monitors and checked against hand-computed values per scenario.
module tb_imem_loader;
    logic clk = 1'b0;
    logic rst = 1'b1;

    imem_loader_if #(.ADDR_W(6)) bus ();

    imem_loader #(.ADDR_W(6), .DEPTH(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int compares   = 0;
    int mismatches = 0;

    int cyc         = 0;
    int last_accept = -1;
    int n_accept    = 0;
    int lat_bad     = 0;
    int rdy_in_wr   = 0;
    logic [5:0]  wr_addr[$];
    logic [31:0] wr_data[$];

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!rst && bus.byte_valid && bus.byte_ready) begin
            n_accept    = n_accept + 1;
            last_accept = cyc;
        end
    end

    always @(negedge clk) begin
        if (bus.imem_we) begin
            wr_addr.push_back(bus.imem_addr);
            wr_data.push_back(bus.imem_wdata);
            if (cyc != last_accept) lat_bad = lat_bad + 1;
            if (bus.byte_ready) rdy_in_wr = rdy_in_wr + 1;
        end
    end

    function automatic void clear_log();
        wr_addr.delete();
        wr_data.delete();
        n_accept  = 0;
        lat_bad   = 0;
        rdy_in_wr = 0;
    endfunction

    function automatic logic [31:0] wd(input int i);
        return (i < wr_data.size()) ? wr_data[i] : 32'hxxxx_xxxx;
    endfunction

    function automatic logic [5:0] wa(input int i);
        return (i < wr_addr.size()) ? wr_addr[i] : 6'bxx_xxxx;
    endfunction

    task automatic pulse_start(input logic [6:0] wc);
        bus.word_count = wc;
        bus.start      = 1'b1;
        @(negedge clk);
        bus.start      = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        bus.byte_valid = 1'b0;
        repeat (gap) @(negedge clk);
        bus.byte_in    = b;
        bus.byte_valid = 1'b1;
        t = 0;
        while (bus.byte_ready !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            compares++;
            mismatches++;
            $display("FAIL send_byte: byte_ready never rose for byte %h (waited %0d cycles)", b, t);
        end
        @(negedge clk);
        bus.byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gap);
    endtask

    task automatic wait_done(input string name);
        int t;
        t = 0;
        while (bus.done !== 1'b1 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2000) begin
            compares++;
            mismatches++;
            $display("FAIL %s wait_done: done still %b after %0d cycles", name, bus.done, t);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        compares += 7;
        if (bus.byte_ready !== 1'b0) begin mismatches++; $display("FAIL reset byte_ready got %b want 0", bus.byte_ready); end
        if (bus.imem_we !== 1'b0) begin mismatches++; $display("FAIL reset imem_we got %b want 0", bus.imem_we); end
        if (bus.imem_addr !== 6'd0) begin mismatches++; $display("FAIL reset imem_addr got %h want 0", bus.imem_addr); end
        if (bus.imem_wdata !== 32'd0) begin mismatches++; $display("FAIL reset imem_wdata got %h want 0", bus.imem_wdata); end
        if (bus.cpu_hold !== 1'b1) begin mismatches++; $display("FAIL reset cpu_hold got %b want 1", bus.cpu_hold); end
        if (bus.done !== 1'b0) begin mismatches++; $display("FAIL reset done got %b want 0", bus.done); end
        if (bus.checksum !== 32'd0) begin mismatches++; $display("FAIL reset checksum got %h want 0", bus.checksum); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_two_word(input int gap, input string name);
        clear_log();
        pulse_start(7'd2);
        compares += 2;
        if (bus.cpu_hold !== 1'b1) begin mismatches++; $display("FAIL %s hold_on_start got %b want 1", name, bus.cpu_hold); end
        if (bus.done !== 1'b0) begin mismatches++; $display("FAIL %s done_on_start got %b want 0", name, bus.done); end
        send_word(32'h0000_0033, gap);
        send_word(32'h0000_2083, gap);
        wait_done(name);
        @(negedge clk);
        compares += 11;
        if (wr_data.size() != 2) begin mismatches++; $display("FAIL %s write_count got %0d want 2", name, wr_data.size()); end
        if (wa(0) !== 6'd0) begin mismatches++; $display("FAIL %s addr0 got %h want 0", name, wa(0)); end
        if (wd(0) !== 32'h0000_0033) begin mismatches++; $display("FAIL %s data0 got %h want 00000033", name, wd(0)); end
        if (wa(1) !== 6'd1) begin mismatches++; $display("FAIL %s addr1 got %h want 1", name, wa(1)); end
        if (wd(1) !== 32'h0000_2083) begin mismatches++; $display("FAIL %s data1 got %h want 00002083", name, wd(1)); end
        if (lat_bad != 0) begin mismatches++; $display("FAIL %s we_latency got %0d late writes want 0", name, lat_bad); end
        if (rdy_in_wr != 0) begin mismatches++; $display("FAIL %s ready_in_write got %0d want 0", name, rdy_in_wr); end
        if (n_accept != 8) begin mismatches++; $display("FAIL %s accepted_bytes got %0d want 8", name, n_accept); end
        if (bus.done !== 1'b1) begin mismatches++; $display("FAIL %s done got %b want 1", name, bus.done); end
        if (bus.cpu_hold !== 1'b0) begin mismatches++; $display("FAIL %s cpu_hold got %b want 0", name, bus.cpu_hold); end
        if (bus.checksum !== 32'h0000_20B6) begin mismatches++; $display("FAIL %s checksum got %h want 000020B6", name, bus.checksum); end
    endtask

    task automatic test_reload();
        clear_log();
        pulse_start(7'd1);
        compares += 2;
        if (bus.cpu_hold !== 1'b1) begin mismatches++; $display("FAIL reload cpu_hold got %b want 1", bus.cpu_hold); end
        if (bus.done !== 1'b0) begin mismatches++; $display("FAIL reload done got %b want 0", bus.done); end
        send_word(32'hFFFF_FFFF, 0);
        wait_done("reload");
        @(negedge clk);
        compares += 4;
        if (wr_data.size() != 1) begin mismatches++; $display("FAIL reload write_count got %0d want 1", wr_data.size()); end
        if (wa(0) !== 6'd0) begin mismatches++; $display("FAIL reload addr0 got %h want 0", wa(0)); end
        if (wd(0) !== 32'hFFFF_FFFF) begin mismatches++; $display("FAIL reload data0 got %h want FFFFFFFF", wd(0)); end
        if (bus.checksum !== 32'hFFFF_FFFF) begin mismatches++; $display("FAIL reload checksum got %h want FFFFFFFF", bus.checksum); end
    endtask

    task automatic test_empty();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        clear_log();
        compares += 1;
        if (bus.done !== 1'b0) begin mismatches++; $display("FAIL empty done_before got %b want 0", bus.done); end
        pulse_start(7'd0);
        compares += 4;
        if (bus.done !== 1'b1) begin mismatches++; $display("FAIL empty done got %b want 1", bus.done); end
        if (bus.cpu_hold !== 1'b0) begin mismatches++; $display("FAIL empty cpu_hold got %b want 0", bus.cpu_hold); end
        repeat (3) @(negedge clk);
        if (wr_data.size() != 0) begin mismatches++; $display("FAIL empty write_count got %0d want 0", wr_data.size()); end
        if (bus.checksum !== 32'd0) begin mismatches++; $display("FAIL empty checksum got %h want 0", bus.checksum); end
    endtask

    task automatic test_saturate();
        logic [31:0] exp_w[64];
        logic [31:0] sum;
        int bad_addr, bad_data;
        clear_log();
        sum = '0;
        for (int i = 0; i < 64; i++) begin
            exp_w[i] = {8'h80 ^ 8'(i), 8'(i + 1), 8'hA5, 8'(i)};
            sum      = sum + exp_w[i];
        end
        pulse_start(7'd70);
        for (int i = 0; i < 64; i++) send_word(exp_w[i], 0);
        wait_done("saturate");
        bus.byte_in    = 8'h5A;
        bus.byte_valid = 1'b1;
        repeat (3) @(negedge clk);
        compares += 1;
        if (bus.byte_ready !== 1'b0) begin mismatches++; $display("FAIL saturate ready_after_done got %b want 0", bus.byte_ready); end
        bus.byte_valid = 1'b0;
        bad_addr = 0;
        bad_data = 0;
        for (int i = 0; i < 64; i++) begin
            if (wa(i) !== 6'(i)) bad_addr++;
            if (wd(i) !== exp_w[i]) bad_data++;
        end
        compares += 7;
        if (wr_data.size() != 64) begin mismatches++; $display("FAIL saturate write_count got %0d want 64", wr_data.size()); end
        if (bad_addr != 0) begin mismatches++; $display("FAIL saturate addr_seq got %0d bad addresses want 0", bad_addr); end
        if (bad_data != 0) begin mismatches++; $display("FAIL saturate data_seq got %0d bad words want 0", bad_data); end
        if (wa(63) !== 6'd63) begin mismatches++; $display("FAIL saturate last_addr got %h want 3f", wa(63)); end
        if (n_accept != 256) begin mismatches++; $display("FAIL saturate accepted_bytes got %0d want 256", n_accept); end
        if (bus.done !== 1'b1) begin mismatches++; $display("FAIL saturate done got %b want 1", bus.done); end
        if (bus.checksum !== sum) begin mismatches++; $display("FAIL saturate checksum got %h want %h", bus.checksum, sum); end
    endtask

    task automatic test_start_busy();
        clear_log();
        pulse_start(7'd3);
        send_word(32'h1111_1111, 0);
        send_byte(8'h22, 0);
        pulse_start(7'd1);
        send_byte(8'h22, 0);
        send_byte(8'h22, 0);
        send_byte(8'h22, 0);
        send_word(32'h3333_3333, 0);
        wait_done("start_busy");
        @(negedge clk);
        compares += 4;
        if (wr_data.size() != 3) begin mismatches++; $display("FAIL start_busy write_count got %0d want 3", wr_data.size()); end
        if (wd(1) !== 32'h2222_2222) begin mismatches++; $display("FAIL start_busy data1 got %h want 22222222", wd(1)); end
        if (wa(2) !== 6'd2) begin mismatches++; $display("FAIL start_busy addr2 got %h want 2", wa(2)); end
        if (bus.checksum !== 32'h6666_6666) begin mismatches++; $display("FAIL start_busy checksum got %h want 66666666", bus.checksum); end
    endtask

    task automatic test_reset_mid();
        clear_log();
        pulse_start(7'd1);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        #2 rst = 1'b1;
        #1;
        compares += 6;
        if (bus.byte_ready !== 1'b0) begin mismatches++; $display("FAIL reset_mid byte_ready got %b want 0", bus.byte_ready); end
        if (bus.imem_addr !== 6'd0) begin mismatches++; $display("FAIL reset_mid imem_addr got %h want 0", bus.imem_addr); end
        if (bus.imem_wdata !== 32'd0) begin mismatches++; $display("FAIL reset_mid imem_wdata got %h want 0", bus.imem_wdata); end
        if (bus.cpu_hold !== 1'b1) begin mismatches++; $display("FAIL reset_mid cpu_hold got %b want 1", bus.cpu_hold); end
        if (bus.done !== 1'b0) begin mismatches++; $display("FAIL reset_mid done got %b want 0", bus.done); end
        if (bus.imem_we !== 1'b0) begin mismatches++; $display("FAIL reset_mid imem_we got %b want 0", bus.imem_we); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        clear_log();
        pulse_start(7'd1);
        send_word(32'h0000_0013, 0);
        wait_done("reset_mid");
        @(negedge clk);
        compares += 4;
        if (wr_data.size() != 1) begin mismatches++; $display("FAIL reset_mid write_count got %0d want 1", wr_data.size()); end
        if (wa(0) !== 6'd0) begin mismatches++; $display("FAIL reset_mid addr0 got %h want 0", wa(0)); end
        if (wd(0) !== 32'h0000_0013) begin mismatches++; $display("FAIL reset_mid data0 got %h want 00000013", wd(0)); end
        if (bus.checksum !== 32'h0000_0013) begin mismatches++; $display("FAIL reset_mid checksum got %h want 00000013", bus.checksum); end
    endtask

    initial begin
        bus.start      = 1'b0;
        bus.word_count = '0;
        bus.byte_in    = '0;
        bus.byte_valid = 1'b0;
        test_reset();
        test_two_word(0, "two_word");
        test_reload();
        test_two_word(2, "backpressure");
        test_empty();
        test_saturate();
        test_start_busy();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, mismatches);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer-side companion to the read-only instruction memory: a boot loader that fills a writable instruction memory before the core runs.
- Accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words.
- Writes each word to consecutive word addresses starting at 0.
- Holds the core in reset until the load completes and reports a running checksum of the words written.

Parameters:
- ADDR_W, 6, word-address width of the instruction memory.
- DEPTH, 64, number of 32-bit words in the instruction memory.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  single-cycle pulse that begins a load; ignored while a load is busy.
- word_count  in  ADDR_W+1  number of words to load, sampled on accepted start; 0..DEPTH.
- byte_in  in  8  incoming stream byte.
- byte_valid  in  1  byte_in is valid.
- byte_ready  out  1  loader accepts a byte this cycle.
- imem_we  out  1  instruction-memory write enable, one cycle per word.
- imem_addr  out  ADDR_W  word address for the write.
- imem_wdata  out  32  assembled instruction word.
- cpu_hold  out  1  holds the core in reset while high.
- done  out  1  load complete.
- checksum  out  32  modulo-2^32 sum of all words written in the current load.

Behaviour:
- Reset values: byte_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_hold=1, done=0, checksum=0. State goes to IDLE.
- Internal counters are cleared on reset: byte_idx (2 bits), word_idx (ADDR_W bits), count register.
- All outputs are registered or decoded directly from state; no combinational path from inputs to outputs.
- Byte transfer occurs only on a cycle where byte_valid=1 and byte_ready=1.
- IDLE:
  - cpu_hold=1, byte_ready=0.
  - On start: latch count = min(word_count, DEPTH), clear checksum, word_idx and byte_idx.
  - Go to DONE if count==0, else go to COLLECT.
- COLLECT:
  - byte_ready=1.
  - On each transfer, place byte_in in byte lane byte_idx of the assembly register: first byte -> bits [7:0], fourth byte -> [31:24]. Then byte_idx++.
  - On the 4th transfer, go to WRITE.
  - byte_valid low simply stalls; there is no timeout.
- WRITE (exactly one cycle):
  - byte_ready=0, imem_we=1, imem_addr=word_idx, imem_wdata=assembled word.
  - checksum += word, updated at the end of this cycle.
  - If word_idx==count-1, go to DONE; else word_idx++ and go to COLLECT.
  - Latency: imem_we is asserted the cycle after the 4th byte is accepted.
- DONE:
  - cpu_hold=0, done=1, byte_ready=0; checksum is held.
  - A new start re-enters the load as from IDLE: done and cpu_hold update on the next cycle to 0 and 1.
- start during COLLECT or WRITE is ignored, and word_count is not re-sampled.
- word_count>DEPTH saturates to DEPTH. The last address written is DEPTH-1; word_idx never wraps.
- imem_addr and imem_wdata hold their last values when imem_we=0.
- rst asserted mid-load:
  - Immediate return to IDLE with reset values; the partial word is discarded.
  - Memory contents already written are not the loader's concern.
- Bytes offered outside COLLECT are not accepted (byte_ready=0) and must be held by the source.

Test Plan:
1. Two-word load:
   - Stimulus: start with word_count=2; bytes 33,00,00,00,83,20,00,00, valid every cycle.
   - Expect: write addr0=0x00000033, then addr1=0x00002083. Each imem_we is one cycle, the cycle after the 4th byte.
   - Expect: done=1, cpu_hold=0, checksum=0x000020B6.
2. Backpressure gaps:
   - Stimulus: same stream, byte_valid toggled 1,0,0,1...
   - Expect: identical writes and checksum; byte_ready=0 during WRITE; no byte is lost or duplicated.
3. Empty and saturated counts:
   - Stimulus: word_count=0.
   - Expect: DONE one cycle after start, no imem_we, checksum=0.
   - Stimulus: word_count=70.
   - Expect: exactly 64 writes, addresses 0..63, last at 63, then done.
4. Start while busy:
   - Stimulus: start with word_count=3; pulse start again with word_count=1 after 5 bytes.
   - Expect: ignored; exactly 3 writes occur.
5. Reset mid-load:
   - Stimulus: assert rst after 2 bytes of word 0.
   - Expect: all outputs at reset values asynchronously.
   - Stimulus: new start with word_count=1 and bytes 13,00,00,00.
   - Expect: addr0=0x00000013; earlier partial bytes are not used.
6. Reload from DONE:
   - Stimulus: after test 1, start with word_count=1 and bytes FF,FF,FF,FF.
   - Expect: cpu_hold returns to 1; addr0=0xFFFFFFFF; checksum=0xFFFFFFFF (cleared, not accumulated).
